// File: rtl/trace_arbiter.sv
// Round-robin arbiter serialising per-core trace requests onto one cache-simulator port.
// Optional WAIT watchdog is enabled by defining ARB_TIMEOUT_EN.
module trace_arbiter #(
  parameter int NUM_CORES      = 4,
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CORES-1:0]          req,
  input  logic [NUM_CORES*ADDR_W-1:0]   req_addr,
  output logic [NUM_CORES-1:0]          ack,
  output logic                          resp_hit,
  output logic                          timeout_err,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic                          trace_ready,
  input  logic                          found_in_cache,
  input  logic                          updated_cache,
  output logic                          busy,
  output logic [$clog2(NUM_CORES)-1:0]  active_core
);

  localparam int IDX_W = $clog2(NUM_CORES);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_ACK} state_t;

  state_t           state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] winner;
  logic             done;
  logic             tmo_hit;

  // First set request bit scanning upward from ptr; index arithmetic wraps naturally.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_CORES-1:0] r,
                                               input logic [IDX_W-1:0] ptr);
    logic [IDX_W-1:0] idx;
    logic             found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int i = 0; i < NUM_CORES; i++) begin
      idx = ptr + i[IDX_W-1:0];
      if (!found && r[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  always_comb begin
    winner = rr_pick(req, rr_ptr);
    done   = found_in_cache | updated_cache;
  end

`ifdef ARB_TIMEOUT_EN
  localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] tmo_cnt;

  // Counts WAIT cycles; sits at zero in every other state so entry to WAIT starts clean.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  tmo_cnt <= '0;
    else if (state != S_WAIT) tmo_cnt <= '0;
    else if (!tmo_hit)        tmo_cnt <= tmo_cnt + 1'b1;
  end

  assign tmo_hit = (state == S_WAIT) && (tmo_cnt == TMO_LAST);
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      rr_ptr      <= '0;
      ack         <= '0;
      resp_hit    <= 1'b0;
      timeout_err <= 1'b0;
      mem_addr    <= '0;
      trace_ready <= 1'b0;
      busy        <= 1'b0;
      active_core <= '0;
    end else begin
      ack         <= '0;
      trace_ready <= 1'b0;
      case (state)
        S_IDLE: begin
          if (|req) begin
            active_core <= winner;
            mem_addr    <= req_addr[winner*ADDR_W +: ADDR_W];
            resp_hit    <= 1'b0;
            timeout_err <= 1'b0;
            trace_ready <= 1'b1;
            busy        <= 1'b1;
            state       <= S_ISSUE;
          end
        end
        S_ISSUE: state <= S_WAIT;
        S_WAIT: begin
          // A real completion in the same cycle as the watchdog takes precedence.
          if (done || tmo_hit) begin
            ack[active_core] <= 1'b1;
            resp_hit         <= found_in_cache;
            timeout_err      <= !done;
            state            <= S_ACK;
          end
        end
        S_ACK: begin
          rr_ptr <= active_core + 1'b1;
          busy   <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trace_arbiter.sv
// Directed self-checking bench for trace_arbiter (4 cores, 32-bit addresses).
module tb_trace_arbiter;

  localparam int NC = 4;
  localparam int AW = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [NC-1:0]   req = '0;
  logic [NC*AW-1:0] req_addr = '0;
  logic [NC-1:0]   ack;
  logic            resp_hit;
  logic            timeout_err;
  logic [AW-1:0]   mem_addr;
  logic            trace_ready;
  logic            found_in_cache = 1'b0;
  logic            updated_cache = 1'b0;
  logic            busy;
  logic [1:0]      active_core;

  int n_checks = 0;
  int n_errors = 0;

  trace_arbiter #(.NUM_CORES(NC), .ADDR_W(AW), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .ack(ack),
    .resp_hit(resp_hit), .timeout_err(timeout_err), .mem_addr(mem_addr),
    .trace_ready(trace_ready), .found_in_cache(found_in_cache),
    .updated_cache(updated_cache), .busy(busy), .active_core(active_core)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int core, input logic [AW-1:0] a);
    req_addr[core*AW +: AW] = a;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_ack"}, 64'(ack), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_trace_ready"}, 64'(trace_ready), 64'(0));
    chk({tag, "_mem_addr"}, 64'(mem_addr), 64'(0));
    chk({tag, "_active_core"}, 64'(active_core), 64'(0));
    chk({tag, "_resp_hit"}, 64'(resp_hit), 64'(0));
    chk({tag, "_timeout_err"}, 64'(timeout_err), 64'(0));
  endtask

  // Entered with the DUT in IDLE and req set so the next edge grants `core`.
  task automatic txn(input string tag, input int core, input logic [AW-1:0] addr,
                     input logic f, input logic u, input int dly, input bit drop);
    logic [NC-1:0] exp_ack;
    exp_ack = '0;
    exp_ack[core] = 1'b1;
    step();
    chk({tag, "_issue_pulse"}, 64'(trace_ready), 64'(1));
    chk({tag, "_issue_busy"}, 64'(busy), 64'(1));
    chk({tag, "_grant_core"}, 64'(active_core), 64'(core));
    chk({tag, "_mem_addr"}, 64'(mem_addr), 64'(addr));
    chk({tag, "_no_early_ack"}, 64'(ack), 64'(0));
    step();
    chk({tag, "_pulse_once"}, 64'(trace_ready), 64'(0));
    if (drop) req[core] = 1'b0;
    for (int i = 0; i < dly; i++) begin
      step();
      chk({tag, "_wait_no_ack"}, 64'(ack), 64'(0));
      chk({tag, "_wait_no_pulse"}, 64'(trace_ready), 64'(0));
    end
    found_in_cache = f;
    updated_cache  = u;
    step();
    found_in_cache = 1'b0;
    updated_cache  = 1'b0;
    chk({tag, "_ack"}, 64'(ack), 64'(exp_ack));
    chk({tag, "_resp_hit"}, 64'(resp_hit), 64'(f));
    chk({tag, "_timeout_err"}, 64'(timeout_err), 64'(0));
    chk({tag, "_ack_busy"}, 64'(busy), 64'(1));
    step();
    chk({tag, "_ack_single"}, 64'(ack), 64'(0));
    chk({tag, "_idle_gap"}, 64'(busy), 64'(0));
    chk({tag, "_hold_addr"}, 64'(mem_addr), 64'(addr));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    #1;
    do_reset();
    chk_idle_outputs("reset");

    // Single request, hit 3 cycles after the issue pulse.
    set_addr(0, 32'h0000_1230);
    req = 4'b0001;
    txn("single", 0, 32'h0000_1230, 1'b1, 1'b0, 2, 1'b0);
    req = 4'b0000;

    // All cores requesting: strict rotation, minimum turnaround, all misses.
    do_reset();
    for (int c = 0; c < NC; c++) set_addr(c, 32'hA000_0000 + 32'(c * 16));
    req = 4'b1111;
    txn("rr0", 0, 32'hA000_0000, 1'b0, 1'b1, 0, 1'b0);
    txn("rr1", 1, 32'hA000_0010, 1'b0, 1'b1, 0, 1'b0);
    txn("rr2", 2, 32'hA000_0020, 1'b0, 1'b1, 0, 1'b0);
    txn("rr3", 3, 32'hA000_0030, 1'b0, 1'b1, 0, 1'b0);
    txn("rr4", 0, 32'hA000_0000, 1'b0, 1'b1, 0, 1'b0);
    req = 4'b0000;

    // Hit and fill together: hit wins, one ack.
    do_reset();
    set_addr(2, 32'h0000_BEE0);
    req = 4'b0100;
    txn("both", 2, 32'h0000_BEE0, 1'b1, 1'b1, 1, 1'b0);
    req = 4'b0000;

    // Reset during WAIT for core 2 (rr_ptr is 3 here); afterwards rotation restarts at 0.
    set_addr(2, 32'h0000_2222);
    req = 4'b0100;
    step();
    chk("abort_grant", 64'(active_core), 64'(2));
    step();
    rst = 1'b1;
    step();
    chk_idle_outputs("abort");
    rst = 1'b0;
    set_addr(0, 32'h0000_0C00);
    set_addr(3, 32'h0000_3C00);
    req = 4'b1101;
    txn("post_abort", 0, 32'h0000_0C00, 1'b0, 1'b1, 0, 1'b0);
    req = 4'b0000;
    step();
    chk("abort_no_ack2", 64'(ack), 64'(0));

    // Core 1 withdraws its request while waiting; the ack still arrives.
    do_reset();
    set_addr(1, 32'h0000_1111);
    req = 4'b0010;
    txn("drop", 1, 32'h0000_1111, 1'b0, 1'b1, 2, 1'b1);
    req = 4'b0000;

    // No completion at all.
    do_reset();
    set_addr(0, 32'h0000_7770);
    req = 4'b0001;
    step();
    chk("stall_pulse", 64'(trace_ready), 64'(1));
    step();
`ifdef ARB_TIMEOUT_EN
    for (int i = 0; i < 7; i++) begin
      step();
      chk("tmo_wait_no_ack", 64'(ack), 64'(0));
    end
    step();
    chk("tmo_ack", 64'(ack), 64'(1));
    chk("tmo_err", 64'(timeout_err), 64'(1));
    chk("tmo_resp_hit", 64'(resp_hit), 64'(0));
    req = 4'b0000;
    step();
    chk("tmo_idle", 64'(busy), 64'(0));
`else
    for (int i = 0; i < 100; i++) begin
      step();
      chk("stall_busy", 64'(busy), 64'(1));
      chk("stall_timeout_err", 64'(timeout_err), 64'(0));
      chk("stall_no_ack", 64'(ack), 64'(0));
    end
    found_in_cache = 1'b1;
    step();
    found_in_cache = 1'b0;
    req = 4'b0000;
    chk("stall_release_ack", 64'(ack), 64'(1));
    chk("stall_release_hit", 64'(resp_hit), 64'(1));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/trace_arbiter.md
# trace_arbiter

Round-robin arbiter that shares one cache-simulator instance between `NUM_CORES` memory-trace sources in the multicore simulator. It accepts per-core address requests and serialises them into single `trace_ready` pulses with `mem_addr` to the cache simulator. It waits for the simulator's completion (`found_in_cache` or `updated_cache`) and returns a one-cycle acknowledge plus hit/miss result to the winning core. It sits between the per-core trace generators and the cache simulator top level.

## Interface
- `NUM_CORES`, 4, number of requesting cores (≥2, power of two).
- `ADDR_W`, 32, address width passed to the cache.
- `TIMEOUT_CYCLES`, 64, watchdog limit in WAIT; used only with `ARB_TIMEOUT_EN`.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req` in NUM_CORES: per-core request level; held until that core's `ack`.
- `req_addr` in NUM_CORES*ADDR_W: core i address in bits [i*ADDR_W +: ADDR_W]; stable while `req[i]`=1.
- `ack` out NUM_CORES: one-hot, one-cycle completion pulse to the served core.
- `resp_hit` out 1: valid with `ack`; 1 = hit, 0 = miss/fill.
- `timeout_err` out 1: valid with `ack`; 1 = transaction aborted by watchdog.
- `mem_addr` out ADDR_W: registered address to the cache simulator.
- `trace_ready` out 1: one-cycle issue pulse to the cache simulator.
- `found_in_cache` in 1: cache hit completion.
- `updated_cache` in 1: miss-and-fill completion.
- `busy` out 1: high in every state except IDLE.
- `active_core` out $clog2(NUM_CORES): index of the core being served.

## Operation
- FSM states: IDLE, ISSUE, WAIT, ACK.
- IDLE: if any `req` is high, select the winner by round robin starting at `rr_ptr`. Latch `active_core` and `mem_addr` from `req_addr[winner]`, then go to ISSUE. Otherwise stay.
- ISSUE: `trace_ready`=1 for exactly this cycle; go to WAIT. Completion inputs are ignored here.
- WAIT: on `found_in_cache` or `updated_cache`, latch `resp_hit` = `found_in_cache` and go to ACK. If both are high, hit wins (`resp_hit`=1).
- ACK: `ack[active_core]`=1 for one cycle with `resp_hit` and `timeout_err` valid. Set `rr_ptr` = `active_core`+1 mod NUM_CORES, then go to IDLE.
- Round robin: the winner is the first set `req` bit scanning `rr_ptr`, `rr_ptr`+1, … with wrap-around. The last winner has lowest priority next round.
- A core dropping `req` mid-transaction is ignored; the transaction completes and `ack` still pulses.
- `req` of the core just acked is not re-granted in the ACK cycle. Earliest re-grant is the next IDLE, subject to round robin.
- `mem_addr`, `active_core`, `resp_hit` and `timeout_err` hold their values until the next grant.

## Timing
- Reset values: state IDLE, `rr_ptr`=0, and every output 0 (`ack`, `resp_hit`, `timeout_err`, `mem_addr`, `trace_ready`, `busy`, `active_core`).
- Reset asserted mid-transaction: immediate return to IDLE, `trace_ready`/`ack` drop, and no ack is ever issued for the aborted request.
- Request seen in IDLE at cycle 0: `trace_ready` and `busy` high at cycle 1. Completion sampled at cycle N≥2 gives `ack` at cycle N+1 and IDLE at N+2.
- Minimum turnaround is 4 cycles per request. Back-to-back grants are separated by exactly one IDLE cycle.
- Exactly one `trace_ready` pulse per grant. `ack` is never asserted for a core that was not granted.

## Configuration
- `ARB_TIMEOUT_EN` defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches `TIMEOUT_CYCLES` with no completion, go to ACK with `timeout_err`=1 and `resp_hit`=0.
  - Round-robin advances normally.
- `ARB_TIMEOUT_EN` undefined: no counter, WAIT holds indefinitely, and `timeout_err` is tied 0.

## Test plan
- Single request: `req`=4'b0001, addr 0x0000_1230, `found_in_cache` 3 cycles after `trace_ready` → `mem_addr`=0x0000_1230, one `trace_ready` pulse, `ack`=4'b0001 with `resp_hit`=1.
- All four request continuously, each completes via `updated_cache` → grant order 0,1,2,3,0; each `ack` has `resp_hit`=0; exactly one IDLE cycle between grants.
- Both `found_in_cache` and `updated_cache` high in the same WAIT cycle → `resp_hit`=1 and a single `ack`.
- `rst` pulsed during WAIT for core 2 → all outputs 0 next cycle, no `ack[2]`; the next grant goes to core 0 (`rr_ptr` reset).
- With `ARB_TIMEOUT_EN` and `TIMEOUT_CYCLES`=8, no completion → `ack` with `timeout_err`=1 after 8 WAIT cycles. Without the macro, `busy` stays high for 100 cycles and `timeout_err` stays 0.
- Core 1 deasserts `req` during WAIT → transaction completes and `ack`=4'b0010 still pulses.
